agc_sequencer: RTL and testbench



---
 rtl/agc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_agc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/agc_sequencer.sv
// AGC measurement sequencer: tick/ce/LFSR strobes, accumulator capture, gated gain apply.
// Optional AGC_SEQ_AUTORESTART_EN: CAPTURE re-enters TICK while enable_i is high.
module agc_sequencer #(
  parameter int NCHAN       = 8,
  parameter int SQ_BITS     = 24,
  parameter int PR_BITS     = 21,
  parameter int PERIOD_BITS = 17,
  parameter int ACC_LATENCY = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       agc_tick_o,
  output logic                       agc_ce_o,
  output logic                       agc_rst_o,
  input  logic [NCHAN*SQ_BITS-1:0]   sq_accum_i,
  input  logic [NCHAN*PR_BITS-1:0]   gt_accum_i,
  input  logic [NCHAN*PR_BITS-1:0]   lt_accum_i,
  output logic [NCHAN*SQ_BITS-1:0]   sq_accum_o,
  output logic [NCHAN*PR_BITS-1:0]   gt_accum_o,
  output logic [NCHAN*PR_BITS-1:0]   lt_accum_o,
  input  logic [16:0]                scale_i,
  input  logic [7:0]                 offset_i,
  input  logic                       scale_wr_i,
  input  logic                       offset_wr_i,
  input  logic                       apply_req_i,
  output logic [16:0]                agc_scale_o,
  output logic [7:0]                 agc_offset_o,
  output logic                       agc_scale_ce_o,
  output logic                       agc_offset_ce_o,
  output logic                       agc_apply_o,
  output logic                       apply_pending_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TICK,
    S_RUN,
    S_FLUSH,
    S_CAPTURE
  } state_t;

  // CAPTURE itself is the ACC_LATENCY-th clock after the last ce, so FLUSH holds one fewer.
  localparam logic [3:0] FLUSH_LAST = 4'(ACC_LATENCY - 2);

  state_t                 state, state_next;
  logic [PERIOD_BITS-1:0] run_cnt, run_cnt_next;
  logic [3:0]             flush_cnt, flush_cnt_next;
  logic                   apply_pending;
  logic                   apply_issue;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      run_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      run_cnt   <= run_cnt_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    run_cnt_next   = run_cnt;
    flush_cnt_next = flush_cnt;
    case (state)
      S_IDLE: begin
        if (start_i && enable_i) state_next = S_TICK;
      end
      S_TICK: begin
        state_next = enable_i ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!enable_i) begin
          state_next   = S_IDLE;
          run_cnt_next = '0;
        end else if (run_cnt == '1) begin
          run_cnt_next = '0;
          state_next   = (ACC_LATENCY > 1) ? S_FLUSH : S_CAPTURE;
        end else begin
          run_cnt_next = run_cnt + 1'b1;
        end
      end
      S_FLUSH: begin
        if (!enable_i) begin
          state_next     = S_IDLE;
          flush_cnt_next = '0;
        end else if (flush_cnt == FLUSH_LAST) begin
          state_next     = S_CAPTURE;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
`ifdef AGC_SEQ_AUTORESTART_EN
        state_next = enable_i ? S_TICK : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_o     = (state != S_IDLE);
  assign agc_tick_o = (state == S_TICK);
  assign agc_ce_o   = (state == S_RUN);

  // Apply waits out any parameter load pulse so cores see the new value before applying.
  assign apply_issue = apply_pending &&
                       ((state == S_IDLE) || (state == S_CAPTURE)) &&
                       !agc_scale_ce_o && !agc_offset_ce_o;
  assign agc_apply_o     = apply_issue;
  assign apply_pending_o = apply_pending;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      agc_rst_o     <= 1'b1;
      done_o        <= 1'b0;
      apply_pending <= 1'b0;
    end else begin
      agc_rst_o     <= !enable_i;
      done_o        <= (state == S_CAPTURE);
      apply_pending <= apply_req_i || (apply_pending && !apply_issue);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_accum_o <= '0;
      gt_accum_o <= '0;
      lt_accum_o <= '0;
    end else if (state == S_CAPTURE) begin
      sq_accum_o <= sq_accum_i;
      gt_accum_o <= gt_accum_i;
      lt_accum_o <= lt_accum_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      agc_scale_o     <= '0;
      agc_offset_o    <= '0;
      agc_scale_ce_o  <= 1'b0;
      agc_offset_ce_o <= 1'b0;
    end else begin
      agc_scale_ce_o  <= scale_wr_i;
      agc_offset_ce_o <= offset_wr_i;
      if (scale_wr_i)  agc_scale_o  <= scale_i;
      if (offset_wr_i) agc_offset_o <= offset_i;
    end
  end

endmodule

// File: tb/tb_agc_sequencer.sv
// Directed cycle-indexed bench for agc_sequencer (PERIOD_BITS=4, ACC_LATENCY=3, NCHAN=2).
module tb_agc_sequencer;

  localparam int NCHAN = 2;
  localparam int SQ_BITS = 24;
  localparam int PR_BITS = 21;
`ifdef AGC_SEQ_AUTORESTART_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i, enable_i, start_i;
  logic busy_o, done_o, agc_tick_o, agc_ce_o, agc_rst_o;
  logic [NCHAN*SQ_BITS-1:0] sq_accum_i, sq_accum_o;
  logic [NCHAN*PR_BITS-1:0] gt_accum_i, lt_accum_i, gt_accum_o, lt_accum_o;
  logic [16:0] scale_i, agc_scale_o;
  logic [7:0]  offset_i, agc_offset_o;
  logic scale_wr_i, offset_wr_i, apply_req_i;
  logic agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, apply_pending_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  agc_sequencer #(
    .NCHAN(NCHAN), .SQ_BITS(SQ_BITS), .PR_BITS(PR_BITS),
    .PERIOD_BITS(4), .ACC_LATENCY(3)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .agc_tick_o(agc_tick_o),
    .agc_ce_o(agc_ce_o), .agc_rst_o(agc_rst_o),
    .sq_accum_i(sq_accum_i), .gt_accum_i(gt_accum_i), .lt_accum_i(lt_accum_i),
    .sq_accum_o(sq_accum_o), .gt_accum_o(gt_accum_o), .lt_accum_o(lt_accum_o),
    .scale_i(scale_i), .offset_i(offset_i),
    .scale_wr_i(scale_wr_i), .offset_wr_i(offset_wr_i), .apply_req_i(apply_req_i),
    .agc_scale_o(agc_scale_o), .agc_offset_o(agc_offset_o),
    .agc_scale_ce_o(agc_scale_ce_o), .agc_offset_ce_o(agc_offset_ce_o),
    .agc_apply_o(agc_apply_o), .apply_pending_o(apply_pending_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit inr(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic [NCHAN*SQ_BITS-1:0] sqv(input int c);
    return {24'(c * 4099 + 17), 24'(c * 313 + 1)};
  endfunction

  function automatic logic [NCHAN*PR_BITS-1:0] gtv(input int c);
    return {21'(c * 77 + 3), 21'(c * 5 + 9)};
  endfunction

  function automatic logic [NCHAN*PR_BITS-1:0] ltv(input int c);
    return {21'(c * 1001), 21'(c + 100)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cap;
    logic [16:0] exp_scale;
    rst_i = 1'b1; enable_i = 1'b1; start_i = 1'b0;
    scale_i = '0; offset_i = '0; scale_wr_i = 1'b0; offset_wr_i = 1'b0; apply_req_i = 1'b0;
    sq_accum_i = '0; gt_accum_i = '0; lt_accum_i = '0;
    #3;
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_ce", 64'(agc_ce_o), 64'd0);
    check_eq("rst_tick", 64'(agc_tick_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_agc_rst", 64'(agc_rst_o), 64'd1);
    check_eq("rst_pending", 64'(apply_pending_o), 64'd0);
    check_eq("rst_sq", 64'(sq_accum_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    cyc = 0;

    // Phases A/B: measurement, apply gating, parameter writes, enable abort.
    while (cyc <= 90) begin
      check_eq("tick", 64'(agc_tick_o),
               64'(cyc == 11 || cyc == 71 || (AR && (cyc == 31 || cyc == 51))));
      check_eq("ce", 64'(agc_ce_o),
               64'(inr(cyc, 12, 27) || inr(cyc, 72, 78) || (AR && (inr(cyc, 32, 47) || inr(cyc, 52, 56)))));
      check_eq("busy", 64'(busy_o),
               64'(inr(cyc, 11, 30) || inr(cyc, 71, 78) || (AR && inr(cyc, 31, 56))));
      check_eq("done", 64'(done_o), 64'(cyc == 31 || (AR && cyc == 51)));
      check_eq("agc_rst", 64'(agc_rst_o), 64'(cyc == 0 || inr(cyc, 57, 60) || cyc >= 79));
      exp_scale = (cyc >= 41) ? 17'h0ABC : (cyc >= 6) ? 17'h1000 : 17'h0;
      check_eq("scale", 64'(agc_scale_o), 64'(exp_scale));
      check_eq("scale_ce", 64'(agc_scale_ce_o), 64'(cyc == 6 || cyc == 41));
      check_eq("offset", 64'(agc_offset_o), (cyc >= 41) ? 64'h5A : 64'h0);
      check_eq("offset_ce", 64'(agc_offset_ce_o), 64'(cyc == 41));
      check_eq("apply", 64'(agc_apply_o),
               64'(cyc == 30 || (AR ? cyc == 50 : (cyc == 31 || cyc == 42))));
      check_eq("pending", 64'(apply_pending_o),
               64'(inr(cyc, 16, AR ? 50 : 31) || (!AR && inr(cyc, 41, 42))));
      cap = (AR && cyc >= 51) ? 50 : (cyc >= 31) ? 30 : -1;
      check_eq("sq_out", 64'(sq_accum_o), (cap < 0) ? 64'd0 : 64'(sqv(cap)));
      check_eq("gt_out", 64'(gt_accum_o), (cap < 0) ? 64'd0 : 64'(gtv(cap)));
      check_eq("lt_out", 64'(lt_accum_o), (cap < 0) ? 64'd0 : 64'(ltv(cap)));

      start_i     = (cyc == 10 || cyc == 20 || cyc == 58 || cyc == 70);
      enable_i    = !(inr(cyc, 56, 59) || cyc >= 78);
      scale_wr_i  = (cyc == 5 || cyc == 40);
      scale_i     = (cyc == 5) ? 17'h1000 : (cyc == 40) ? 17'h0ABC : 17'(cyc * 37 + 3);
      offset_wr_i = (cyc == 40);
      offset_i    = (cyc == 40) ? 8'h5A : 8'(cyc);
      apply_req_i = (cyc == 15 || cyc == 30 || cyc == 40);
      sq_accum_i  = sqv(cyc);
      gt_accum_i  = gtv(cyc);
      lt_accum_i  = ltv(cyc);
      @(posedge clk); #1;
      cyc++;
    end

    // Phase C: asynchronous reset in the middle of RUN.
    start_i = 1'b0; scale_wr_i = 1'b0; offset_wr_i = 1'b0; apply_req_i = 1'b0;
    while (cyc <= 100) begin
      check_eq("c_tick", 64'(agc_tick_o), 64'(cyc == 93));
      check_eq("c_ce", 64'(agc_ce_o), 64'(inr(cyc, 94, 100)));
      check_eq("c_busy", 64'(busy_o), 64'(inr(cyc, 93, 100)));
      enable_i = 1'b1;
      start_i  = (cyc == 92);
      if (cyc == 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_ce", 64'(agc_ce_o), 64'd0);
    check_eq("arst_busy", 64'(busy_o), 64'd0);
    check_eq("arst_agc_rst", 64'(agc_rst_o), 64'd1);
    check_eq("arst_sq", 64'(sq_accum_o), 64'd0);
    check_eq("arst_scale", 64'(agc_scale_o), 64'd0);
    check_eq("arst_offset", 64'(agc_offset_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    cyc++;
    @(posedge clk); #1;
    cyc++;
    check_eq("post_busy", 64'(busy_o), 64'd0);
    check_eq("post_agc_rst", 64'(agc_rst_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
